// File: rtl/node_port_buffer_pkg.sv
// Shared definitions for the node port buffer and its FIFOs.
package node_port_buffer_pkg;

  // Packet widths shared with router_core's Packet_From_Node / Packet_To_Node.
  localparam int NODE_TX_W = 29;
  localparam int NODE_RX_W = 24;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/node_port_fifo.sv
// Show-ahead FIFO with a simultaneous push/pop when full and a saturating
// counter of rejected pushes. DEPTH must be a power of two (pointers wrap).
module node_port_fifo
  import node_port_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;
  logic             do_drop;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside it; an ack or pop while empty is simply ignored.
  assign do_pop  = pop_req && valid;
  assign do_push = push_req && (!full || do_pop);
  assign do_drop = push_req && !do_push;

  // Masking with valid keeps the head all-zero after reset and never X, even
  // though the storage array itself is not reset.
  assign head = valid ? mem[rd_ptr] : '0;

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and count define which
  // entries are live, and resetting the array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer, occupancy and drop-counter state, synchronously reset.
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: rtl/node_port_buffer.sv
// Bidirectional packet buffer between the processor node and router_core.
// Outbound node packets wait for Core_Load_Ack; inbound deliveries, which
// router_core cannot stall, wait for Node_Rx_Pop. Losses are counted.
module node_port_buffer
  import node_port_buffer_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 Clk_R,
  input  logic                 Rst_n,
  input  logic [NODE_TX_W-1:0] Node_Tx_Data,
  input  logic                 Node_Tx_Valid,
  output logic                 Node_Tx_Full,
  output logic [NODE_TX_W-1:0] Packet_From_Node,
  output logic                 Packet_From_Node_Valid,
  input  logic                 Core_Load_Ack,
  input  logic [NODE_RX_W-1:0] Packet_To_Node,
  input  logic                 Packet_To_Node_Valid,
  output logic [NODE_RX_W-1:0] Node_Rx_Data,
  output logic                 Node_Rx_Valid,
  input  logic                 Node_Rx_Pop,
  output logic [CNT_W-1:0]     Tx_Drop_Count,
  output logic [CNT_W-1:0]     Rx_Drop_Count
);

  // The node learns of inbound loss only through Rx_Drop_Count.
  logic rx_full_unused;

  // Node -> router_core.
  node_port_fifo #(
    .WIDTH (NODE_TX_W),
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .clk        (Clk_R),
    .rst_n      (Rst_n),
    .push_req   (Node_Tx_Valid),
    .push_data  (Node_Tx_Data),
    .pop_req    (Core_Load_Ack),
    .full       (Node_Tx_Full),
    .valid      (Packet_From_Node_Valid),
    .head       (Packet_From_Node),
    .drop_count (Tx_Drop_Count)
  );

  // router_core -> node.
  node_port_fifo #(
    .WIDTH (NODE_RX_W),
    .DEPTH (IN_DEPTH),
    .CNT_W (CNT_W)
  ) u_in_fifo (
    .clk        (Clk_R),
    .rst_n      (Rst_n),
    .push_req   (Packet_To_Node_Valid),
    .push_data  (Packet_To_Node),
    .pop_req    (Node_Rx_Pop),
    .full       (rx_full_unused),
    .valid      (Node_Rx_Valid),
    .head       (Node_Rx_Data),
    .drop_count (Rx_Drop_Count)
  );

endmodule

// File: tb/tb_node_port_buffer.sv
// Bench for node_port_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_node_port_buffer;

  localparam int OUT_DEPTH = 4;
  localparam int IN_DEPTH  = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = 255;

  logic        Clk_R;
  logic        Rst_n;
  logic [28:0] Node_Tx_Data;
  logic        Node_Tx_Valid;
  logic        Node_Tx_Full;
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  logic [23:0] Packet_To_Node;
  logic        Packet_To_Node_Valid;
  logic [23:0] Node_Rx_Data;
  logic        Node_Rx_Valid;
  logic        Node_Rx_Pop;
  logic [7:0]  Tx_Drop_Count;
  logic [7:0]  Rx_Drop_Count;

  node_port_buffer #(
    .OUT_DEPTH (OUT_DEPTH),
    .IN_DEPTH  (IN_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk_R                  (Clk_R),
    .Rst_n                  (Rst_n),
    .Node_Tx_Data           (Node_Tx_Data),
    .Node_Tx_Valid          (Node_Tx_Valid),
    .Node_Tx_Full           (Node_Tx_Full),
    .Packet_From_Node       (Packet_From_Node),
    .Packet_From_Node_Valid (Packet_From_Node_Valid),
    .Core_Load_Ack          (Core_Load_Ack),
    .Packet_To_Node         (Packet_To_Node),
    .Packet_To_Node_Valid   (Packet_To_Node_Valid),
    .Node_Rx_Data           (Node_Rx_Data),
    .Node_Rx_Valid          (Node_Rx_Valid),
    .Node_Rx_Pop            (Node_Rx_Pop),
    .Tx_Drop_Count          (Tx_Drop_Count),
    .Rx_Drop_Count          (Rx_Drop_Count)
  );

  initial Clk_R = 1'b0;
  always #5 Clk_R = ~Clk_R;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and counters following the buffering rules.
  logic [28:0] q_out[$];
  logic [23:0] q_in[$];
  int          tx_drops = 0;
  int          rx_drops = 0;
  bit          chk_en   = 0;
  bit          m_pop;

  always @(posedge Clk_R) begin
    if (!Rst_n) begin
      q_out.delete();
      q_in.delete();
      tx_drops = 0;
      rx_drops = 0;
      chk_en   = 1;
    end else begin
      m_pop = Core_Load_Ack && (q_out.size() > 0);
      if (Node_Tx_Valid && (q_out.size() < OUT_DEPTH || m_pop)) begin
        if (m_pop) void'(q_out.pop_front());
        q_out.push_back(Node_Tx_Data);
      end else begin
        if (m_pop) void'(q_out.pop_front());
        if (Node_Tx_Valid && tx_drops < CNT_MAX) tx_drops++;
      end

      m_pop = Node_Rx_Pop && (q_in.size() > 0);
      if (Packet_To_Node_Valid && (q_in.size() < IN_DEPTH || m_pop)) begin
        if (m_pop) void'(q_in.pop_front());
        q_in.push_back(Packet_To_Node);
      end else begin
        if (m_pop) void'(q_in.pop_front());
        if (Packet_To_Node_Valid && rx_drops < CNT_MAX) rx_drops++;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge Clk_R) begin
    if (chk_en) begin
      check("tx_full",  Node_Tx_Full,           q_out.size() == OUT_DEPTH);
      check("tx_valid", Packet_From_Node_Valid, q_out.size() != 0);
      check("tx_known", $isunknown(Packet_From_Node), 1'b0);
      if (q_out.size() != 0) check("tx_head", Packet_From_Node, q_out[0]);
      check("rx_valid", Node_Rx_Valid,          q_in.size() != 0);
      check("rx_known", $isunknown(Node_Rx_Data), 1'b0);
      if (q_in.size() != 0) check("rx_head", Node_Rx_Data, q_in[0]);
      check("tx_drop",  Tx_Drop_Count,          tx_drops);
      check("rx_drop",  Rx_Drop_Count,          rx_drops);
    end
  end

  // One clock edge; returns 1 time unit after it so outputs have settled.
  task automatic cyc();
    @(posedge Clk_R);
    #1;
  endtask

  initial begin
    Rst_n                = 1'b0;
    Node_Tx_Data         = '0;
    Node_Tx_Valid        = 1'b0;
    Core_Load_Ack        = 1'b0;
    Packet_To_Node       = '0;
    Packet_To_Node_Valid = 1'b0;
    Node_Rx_Pop          = 1'b0;
    cyc();
    cyc();
    Rst_n = 1'b1;

    // Reset state.
    check("rst_tx_full",  Node_Tx_Full, 0);
    check("rst_tx_valid", Packet_From_Node_Valid, 0);
    check("rst_rx_valid", Node_Rx_Valid, 0);
    check("rst_tx_drop",  Tx_Drop_Count, 0);
    check("rst_rx_drop",  Rx_Drop_Count, 0);
    check("rst_tx_data",  Packet_From_Node, 0);
    check("rst_rx_data",  Node_Rx_Data, 0);

    // Single push, no combinational valid path, one ack drains it.
    Node_Tx_Valid = 1'b1;
    Node_Tx_Data  = 29'h0ABCDEF;
    #1;
    check("t1_no_comb", Packet_From_Node_Valid, 0);
    cyc();
    Node_Tx_Valid = 1'b0;
    check("t1_valid", Packet_From_Node_Valid, 1);
    check("t1_data",  Packet_From_Node, 29'h0ABCDEF);
    Core_Load_Ack = 1'b1;
    cyc();
    Core_Load_Ack = 1'b0;
    check("t1_drained", Packet_From_Node_Valid, 0);
    check("t1_drop",    Tx_Drop_Count, 0);

    // Five back-to-back pushes into a depth-4 FIFO: fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      Node_Tx_Valid = 1'b1;
      Node_Tx_Data  = 29'h100 + 29'(i);
      cyc();
      if (i == 3) check("t2_not_full_3", Node_Tx_Full, 0);
      if (i == 4) check("t2_full_4", Node_Tx_Full, 1);
    end
    Node_Tx_Valid = 1'b0;
    check("t2_drop", Tx_Drop_Count, 1);
    for (int i = 1; i <= 4; i++) begin
      check("t2_order", Packet_From_Node, 32'h100 + 32'(i));
      Core_Load_Ack = 1'b1;
      cyc();
      Core_Load_Ack = 1'b0;
    end
    check("t2_empty", Packet_From_Node_Valid, 0);

    // Empty FIFO with push and ack together: ack ignored, push lands.
    Node_Tx_Valid = 1'b1;
    Node_Tx_Data  = 29'h77;
    Core_Load_Ack = 1'b1;
    cyc();
    Node_Tx_Valid = 1'b0;
    Core_Load_Ack = 1'b0;
    check("t3_empty_pa_valid", Packet_From_Node_Valid, 1);
    check("t3_empty_pa_data",  Packet_From_Node, 29'h77);
    Core_Load_Ack = 1'b1;
    cyc();
    Core_Load_Ack = 1'b0;

    // Full FIFO with push and ack together: stays full, new packet is 4th.
    for (int i = 1; i <= 4; i++) begin
      Node_Tx_Valid = 1'b1;
      Node_Tx_Data  = 29'h200 + 29'(i);
      cyc();
    end
    Node_Tx_Data  = 29'h2FF;
    Core_Load_Ack = 1'b1;
    cyc();
    Node_Tx_Valid = 1'b0;
    Core_Load_Ack = 1'b0;
    check("t3_full_stays", Node_Tx_Full, 1);
    check("t3_head",       Packet_From_Node, 29'h202);
    check("t3_no_drop",    Tx_Drop_Count, 1);
    for (int i = 0; i < 4; i++) begin
      Core_Load_Ack = 1'b1;
      cyc();
      Core_Load_Ack = 1'b0;
    end
    check("t3_drained", Packet_From_Node_Valid, 0);
    // Ack while empty changes nothing.
    Core_Load_Ack = 1'b1;
    cyc();
    Core_Load_Ack = 1'b0;
    check("t3_ack_empty_valid", Packet_From_Node_Valid, 0);
    check("t3_ack_empty_full",  Node_Tx_Full, 0);
    check("t3_ack_empty_drop",  Tx_Drop_Count, 1);

    // Inbound strobe held 6 cycles with no pops: 4 kept, 2 lost.
    for (int i = 1; i <= 6; i++) begin
      Packet_To_Node_Valid = 1'b1;
      Packet_To_Node       = 24'(i);
      cyc();
      if (i == 1) check("t4_latency", Node_Rx_Valid, 1);
    end
    Packet_To_Node_Valid = 1'b0;
    check("t4_head", Node_Rx_Data, 24'h1);
    check("t4_drop", Rx_Drop_Count, 2);
    for (int i = 1; i <= 4; i++) begin
      check("t4_order", Node_Rx_Data, 32'(i));
      Node_Rx_Pop = 1'b1;
      cyc();
      Node_Rx_Pop = 1'b0;
    end
    check("t4_empty", Node_Rx_Valid, 0);
    Node_Rx_Pop = 1'b1;
    cyc();
    Node_Rx_Pop = 1'b0;
    check("t4_pop_empty", Node_Rx_Valid, 0);

    // Inbound full with delivery and pop together: no loss.
    for (int i = 1; i <= 4; i++) begin
      Packet_To_Node_Valid = 1'b1;
      Packet_To_Node       = 24'h10 + 24'(i);
      cyc();
    end
    Packet_To_Node = 24'h15;
    Node_Rx_Pop    = 1'b1;
    cyc();
    Packet_To_Node_Valid = 1'b0;
    Node_Rx_Pop          = 1'b0;
    check("t4_full_pp_head", Node_Rx_Data, 24'h12);
    check("t4_full_pp_drop", Rx_Drop_Count, 2);
    for (int i = 0; i < 2; i++) begin
      Node_Rx_Pop = 1'b1;
      cyc();
      Node_Rx_Pop = 1'b0;
    end
    check("t4_partial_head", Node_Rx_Data, 24'h14);

    // Drop counter saturation: fill, then 300 pushes with no ack.
    Node_Tx_Valid = 1'b1;
    for (int i = 1; i <= 4 + 300; i++) begin
      Node_Tx_Data = 29'h300 + 29'(i);
      cyc();
    end
    Node_Tx_Valid = 1'b0;
    check("t5_saturated", Tx_Drop_Count, 8'hFF);
    check("t5_head_kept", Packet_From_Node, 29'h301);
    Node_Tx_Valid = 1'b1;
    cyc();
    Node_Tx_Valid = 1'b0;
    check("t5_no_wrap", Tx_Drop_Count, 8'hFF);
    Core_Load_Ack = 1'b1;
    cyc();
    Core_Load_Ack = 1'b0;

    // Reset with both FIFOs partially filled, then a fresh push each way.
    Rst_n = 1'b0;
    cyc();
    Rst_n = 1'b1;
    check("t6_tx_valid", Packet_From_Node_Valid, 0);
    check("t6_tx_full",  Node_Tx_Full, 0);
    check("t6_rx_valid", Node_Rx_Valid, 0);
    check("t6_tx_drop",  Tx_Drop_Count, 0);
    check("t6_rx_drop",  Rx_Drop_Count, 0);
    Node_Tx_Valid        = 1'b1;
    Node_Tx_Data         = 29'h1234567;
    Packet_To_Node_Valid = 1'b1;
    Packet_To_Node       = 24'hABCDEF;
    cyc();
    Node_Tx_Valid        = 1'b0;
    Packet_To_Node_Valid = 1'b0;
    check("t6_tx_fresh_valid", Packet_From_Node_Valid, 1);
    check("t6_tx_fresh_data",  Packet_From_Node, 29'h1234567);
    check("t6_rx_fresh_valid", Node_Rx_Valid, 1);
    check("t6_rx_fresh_data",  Node_Rx_Data, 24'hABCDEF);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
